// File: rtl/calc_display_seq_pkg.sv
// Shared definitions for the calculator display sequencer: FSM state
// encoding and the special digit codes understood by the segment decoders.
`timescale 1ns/1ps
package calc_disp_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_CALC = 2'b10,
    S_RES  = 2'b11
  } calc_state_t;

  // Digit codes the decoder renders as an unlit digit and as "E".
  localparam int BLANK_CODE  = 11;
  localparam int ERR_CODE    = 14;

  // Default width of one digit code.
  localparam int DEF_DIGIT_W = 5;

endpackage

// File: rtl/calc_display_seq_zero_blanker.sv
// zero_blanker: purely combinational leading-zero suppression.
// Zero digits above the most significant nonzero digit become BLANK_CODE;
// digit 0 always passes through, so an all-zero value shows a single "0".
`timescale 1ns/1ps
module zero_blanker
  import calc_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = DEF_DIGIT_W
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_out
);

  localparam logic [DIGIT_W-1:0] BLANK_D = DIGIT_W'(BLANK_CODE);

  logic leading;

  // Walk from the top digit down, blanking zeros until the first nonzero digit.
  always_comb begin
    // NOTE: blocking assignments here, because 'leading' must carry its
    // updated value to the next loop iteration within the same evaluation.
    digits_out = digits_in;
    leading    = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (leading && (digits_in[i*DIGIT_W +: DIGIT_W] == '0)) begin
        digits_out[i*DIGIT_W +: DIGIT_W] = BLANK_D;
      end else begin
        leading = 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_display_seq.sv
// calc_display_seq: display sequencer for the calculator datapath.
// Steps operand A entry, operand B entry, a start/done handshake with the
// math unit (with timeout), then result display with leading-zero blanking.
// Optional operand blinking is enabled by defining CALC_DISP_BLINK_EN.
`timescale 1ns/1ps
module calc_display_seq
  import calc_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int OPND_DIGITS = 2,
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int TIMEOUT_CYC = 1023,
  parameter int BLINK_DIV   = 2**22
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [OPND_DIGITS*DIGIT_W-1:0] opnd_a,
  input  logic [OPND_DIGITS*DIGIT_W-1:0] opnd_b,
  input  logic                          enter,
  input  logic                          clear,
  output logic                          math_start,
  input  logic                          math_done,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] result_digits,
  input  logic                          result_err,
  output logic [NUM_DIGITS*DIGIT_W-1:0] disp_digits,
  output logic [1:0]                    disp_state,
  output logic                          busy
);

  localparam int DISP_W = NUM_DIGITS * DIGIT_W;
  localparam int OPND_W = OPND_DIGITS * DIGIT_W;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DIGIT_W-1:0] BLANK_D  = DIGIT_W'(BLANK_CODE);
  localparam logic [DIGIT_W-1:0] ERR_D    = DIGIT_W'(ERR_CODE);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  // Reject parameter combinations the datapath cannot represent.
  if (OPND_DIGITS < 1 || OPND_DIGITS > NUM_DIGITS) begin : g_bad_opnd
    $error("calc_display_seq: OPND_DIGITS must be in 1..NUM_DIGITS");
  end
  if (TIMEOUT_CYC < 1 || BLINK_DIV < 1) begin : g_bad_count
    $error("calc_display_seq: TIMEOUT_CYC and BLINK_DIV must be >= 1");
  end

  calc_state_t         state;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                tmo_hit;
  logic                err_flag;
  logic [DISP_W-1:0]   result_q;
  logic [DISP_W-1:0]   res_blanked;
  logic [DISP_W-1:0]   opnd_frame;
  logic                blank_opnd;

  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign disp_state = state;

  // Main sequencer: state, handshake, timeout counter and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every register here, including the result store, has a defined
    // reset value so a reset mid-calculation leaves nothing stale behind.
    if (!reset_n) begin
      state      <= S_A;
      math_start <= 1'b0;
      busy       <= 1'b0;
      err_flag   <= 1'b0;
      tmo_cnt    <= '0;
      result_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // samples the pre-edge values regardless of statement order.
      math_start <= 1'b0;
      if (clear) begin
        state    <= S_A;
        busy     <= 1'b0;
        err_flag <= 1'b0;
        tmo_cnt  <= '0;
      end else begin
        case (state)
          S_A: begin
            if (enter) state <= S_B;
          end
          S_B: begin
            if (enter) begin
              state      <= S_CALC;
              math_start <= 1'b1;
              busy       <= 1'b1;
              tmo_cnt    <= '0;
            end
          end
          S_CALC: begin
            if (math_done) begin
              result_q <= result_digits;
              err_flag <= result_err;
              state    <= S_RES;
              busy     <= 1'b0;
              tmo_cnt  <= '0;
            end else if (tmo_hit) begin
              err_flag <= 1'b1;
              state    <= S_RES;
              busy     <= 1'b0;
              tmo_cnt  <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          S_RES: begin
            if (enter) begin
              state    <= S_A;
              err_flag <= 1'b0;
            end
          end
          default: state <= S_A;
        endcase
      end
    end
  end

  zero_blanker #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_zero_blanker (
    .digits_in  (result_q),
    .digits_out (res_blanked)
  );

`ifdef CALC_DISP_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               state_change;

  // Flags the cycles on which the sequencer moves to a different state.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    state_change = 1'b0;
    if (clear) begin
      state_change = (state != S_A);
    end else begin
      case (state)
        S_CALC:  state_change = math_done || tmo_hit;
        default: state_change = enter;
      endcase
    end
  end

  // Blink phase generator, restarted at phase 0 on every state entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (state_change) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank_opnd = blink_phase;
`else
  assign blank_opnd = 1'b0;
`endif

  // Operand view: blank upper digits, live operand right-aligned below.
  always_comb begin
    opnd_frame = {NUM_DIGITS{BLANK_D}};
    if (!blank_opnd) begin
      opnd_frame[OPND_W-1:0] = (state == S_B) ? opnd_b : opnd_a;
    end
  end

  // Registered display: operands live, held during compute, result or error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_digits <= {NUM_DIGITS{BLANK_D}};
    end else begin
      case (state)
        S_A, S_B: disp_digits <= opnd_frame;
        S_RES:    disp_digits <= err_flag ? {NUM_DIGITS{ERR_D}} : res_blanked;
        default:  disp_digits <= disp_digits;
      endcase
    end
  end

endmodule
